// File: rtl/sd_card_pkg.sv
// Shared constants, FSM states and CRC7 step function for the SD card CMD responder.
package sd_card_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RX        = 3'd1,
    RESP_WAIT = 3'd2,
    NCR_WAIT  = 3'd3,
    TX        = 3'd4
  } sd_state_e;

  localparam logic [6:0]  CRC7_POLY  = 7'h09;
  localparam int unsigned FRAME_BITS = 48;
  localparam int unsigned HDR_BITS   = 40;
  localparam int unsigned CNT_W      = 6;
  localparam logic [6:0]  R3_CRC     = 7'h7F;

  // One MSB-first step of CRC7 (x^7 + x^3 + 1).
  function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic din);
    logic fb;
    fb = crc[6] ^ din;
    crc7_step = {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
  endfunction

endpackage

// File: rtl/sd_crc7_serial.sv
// Serial CRC7, one bit per enable; clear and en together restart the CRC with din.
module sd_crc7_serial
  import sd_card_pkg::*;
(
  input  logic       ex_clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       en,
  input  logic       din,
  output logic [6:0] crc
);

  logic [6:0] crc_q;
  logic [6:0] crc_d;
  logic [6:0] base_c;

  // Next CRC: clear zeroes the seed, en folds one bit in.
  always_comb begin
    base_c = clear ? 7'h00 : crc_q;
    crc_d  = crc_q;
    if (en) begin
      crc_d = crc7_step(base_c, din);
    end else if (clear) begin
      crc_d = 7'h00;
    end
  end

  // CRC register.
  always_ff @(posedge ex_clk) begin
    if (reset) begin
      crc_q <= 7'h00;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc = crc_q;

endmodule

// File: rtl/sd_card_cmd_responder.sv
// Card-side SD CMD line: receives 48-bit commands with CRC7 check, sends 48-bit responses.
module sd_card_cmd_responder
  import sd_card_pkg::*;
#(
  parameter int unsigned NCR = 2
) (
  input  logic        ex_clk,
  input  logic        reset,
  input  logic        sd_clk,
  input  logic        cmd_in,
  output logic        cmd_out,
  output logic        cmd_oe,
  output logic        cmd_valid,
  output logic [5:0]  cmd_index,
  output logic [31:0] cmd_arg,
  output logic        cmd_crc_err,
  input  logic        resp_start,
  input  logic        resp_skip,
  input  logic [5:0]  resp_index,
  input  logic [31:0] resp_arg,
  input  logic        resp_no_crc,
  output logic        resp_done
);

  localparam logic [CNT_W-1:0] CNT_CRC_LO = CNT_W'(FRAME_BITS - HDR_BITS);
  localparam logic [CNT_W-1:0] CNT_RX_TOP = CNT_W'(FRAME_BITS - 2);
  localparam logic [CNT_W-1:0] CNT_TX_TOP = CNT_W'(FRAME_BITS - 1);
  localparam logic [CNT_W-1:0] CNT_WRAP   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_NCR    = CNT_W'(NCR - 1);

  sd_state_e              state_q, state_d;
  logic                   sd_clk_q;
  logic [FRAME_BITS-1:0]  shreg_q, shreg_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   no_crc_q, no_crc_d;
  logic                   cmd_out_q, cmd_out_d;
  logic                   cmd_oe_q, cmd_oe_d;
  logic                   cmd_valid_q, cmd_valid_d;
  logic [5:0]             cmd_index_q, cmd_index_d;
  logic [31:0]            cmd_arg_q, cmd_arg_d;
  logic                   cmd_crc_err_q, cmd_crc_err_d;
  logic                   done_pend_q, done_pend_d;
  logic                   resp_done_q, resp_done_d;

  logic                   rise_c, fall_c, start_bit_c;
  logic [FRAME_BITS-2:0]  frame_c;
  logic [HDR_BITS-1:0]    hdr_c;
  logic [2:0]             crc_bit_c;
  logic                   rx_clear_c, rx_en_c;
  logic                   tx_clear_c, tx_en_c;
  logic [6:0]             rx_crc, tx_crc;

  // sd_clk edge detection on the oversampled input.
  assign rise_c      = sd_clk & ~sd_clk_q;
  assign fall_c      = ~sd_clk & sd_clk_q;
  assign start_bit_c = rise_c & ~cmd_in & ~cmd_oe_q;
  assign frame_c     = {shreg_q[FRAME_BITS-3:0], cmd_in};
  assign hdr_c       = {2'b00, resp_index, resp_arg};
  assign crc_bit_c   = 3'(cnt_q - CNT_W'(1));

  sd_crc7_serial u_rx_crc (
    .ex_clk (ex_clk),
    .reset  (reset),
    .clear  (rx_clear_c),
    .en     (rx_en_c),
    .din    (cmd_in),
    .crc    (rx_crc)
  );

  sd_crc7_serial u_tx_crc (
    .ex_clk (ex_clk),
    .reset  (reset),
    .clear  (tx_clear_c),
    .en     (tx_en_c),
    .din    (shreg_q[FRAME_BITS-1]),
    .crc    (tx_crc)
  );

  // Next-state and output logic for the receive / response FSM.
  always_comb begin
    state_d       = state_q;
    shreg_d       = shreg_q;
    cnt_d         = cnt_q;
    no_crc_d      = no_crc_q;
    cmd_out_d     = cmd_out_q;
    cmd_oe_d      = cmd_oe_q;
    cmd_valid_d   = 1'b0;
    cmd_index_d   = cmd_index_q;
    cmd_arg_d     = cmd_arg_q;
    cmd_crc_err_d = cmd_crc_err_q;
    done_pend_d   = 1'b0;
    resp_done_d   = done_pend_q;
    rx_clear_c    = 1'b0;
    rx_en_c       = 1'b0;
    tx_clear_c    = 1'b0;
    tx_en_c       = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_bit_c) begin
          state_d    = RX;
          cnt_d      = CNT_RX_TOP;
          shreg_d    = {shreg_q[FRAME_BITS-2:0], cmd_in};
          rx_clear_c = 1'b1;
          rx_en_c    = 1'b1;
        end
      end

      RX: begin
        if (rise_c) begin
          shreg_d = {shreg_q[FRAME_BITS-2:0], cmd_in};
          rx_en_c = (cnt_q >= CNT_CRC_LO);
          if (cnt_q == '0) begin
            if (!frame_c[FRAME_BITS-2] || !frame_c[0]) begin
              state_d = IDLE;
            end else begin
              cmd_valid_d   = 1'b1;
              cmd_index_d   = frame_c[45:40];
              cmd_arg_d     = frame_c[39:8];
              cmd_crc_err_d = (frame_c[7:1] != rx_crc);
              state_d       = (frame_c[7:1] != rx_crc) ? IDLE : RESP_WAIT;
            end
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end

      RESP_WAIT: begin
        if (resp_start) begin
          state_d    = NCR_WAIT;
          shreg_d    = {hdr_c, 8'h00};
          no_crc_d   = resp_no_crc;
          cnt_d      = CNT_NCR;
          tx_clear_c = 1'b1;
        end else if (resp_skip) begin
          state_d = IDLE;
        end else if (start_bit_c) begin
          state_d    = RX;
          cnt_d      = CNT_RX_TOP;
          shreg_d    = {shreg_q[FRAME_BITS-2:0], cmd_in};
          rx_clear_c = 1'b1;
          rx_en_c    = 1'b1;
        end
      end

      // CMD stays released for NCR falls; the first TX fall drives the start bit.
      NCR_WAIT: begin
        if (fall_c) begin
          if (cnt_q == '0) begin
            state_d = TX;
            cnt_d   = CNT_TX_TOP;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end

      // cnt_q is the frame bit driven on this fall; wrap past bit 0 ends the frame.
      TX: begin
        if (fall_c) begin
          if (cnt_q == CNT_WRAP) begin
            cmd_oe_d    = 1'b0;
            cmd_out_d   = 1'b1;
            done_pend_d = 1'b1;
            state_d     = IDLE;
          end else begin
            cmd_oe_d = 1'b1;
            cnt_d    = cnt_q - CNT_W'(1);
            if (cnt_q >= CNT_CRC_LO) begin
              cmd_out_d = shreg_q[FRAME_BITS-1];
              shreg_d   = {shreg_q[FRAME_BITS-2:0], 1'b0};
              tx_en_c   = 1'b1;
            end else if (cnt_q != '0) begin
              cmd_out_d = no_crc_q ? R3_CRC[crc_bit_c] : tx_crc[crc_bit_c];
            end else begin
              cmd_out_d = 1'b1;
            end
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge ex_clk) begin
    if (reset) begin
      state_q       <= IDLE;
      sd_clk_q      <= 1'b0;
      shreg_q       <= '0;
      cnt_q         <= '0;
      no_crc_q      <= 1'b0;
      cmd_out_q     <= 1'b1;
      cmd_oe_q      <= 1'b0;
      cmd_valid_q   <= 1'b0;
      cmd_index_q   <= 6'd0;
      cmd_arg_q     <= 32'd0;
      cmd_crc_err_q <= 1'b0;
      done_pend_q   <= 1'b0;
      resp_done_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      sd_clk_q      <= sd_clk;
      shreg_q       <= shreg_d;
      cnt_q         <= cnt_d;
      no_crc_q      <= no_crc_d;
      cmd_out_q     <= cmd_out_d;
      cmd_oe_q      <= cmd_oe_d;
      cmd_valid_q   <= cmd_valid_d;
      cmd_index_q   <= cmd_index_d;
      cmd_arg_q     <= cmd_arg_d;
      cmd_crc_err_q <= cmd_crc_err_d;
      done_pend_q   <= done_pend_d;
      resp_done_q   <= resp_done_d;
    end
  end

  assign cmd_out     = cmd_out_q;
  assign cmd_oe      = cmd_oe_q;
  assign cmd_valid   = cmd_valid_q;
  assign cmd_index   = cmd_index_q;
  assign cmd_arg     = cmd_arg_q;
  assign cmd_crc_err = cmd_crc_err_q;
  assign resp_done   = resp_done_q;

endmodule

// File: tb/tb_sd_card_cmd_responder.sv
// Self-checking bench: host-side CMD line model driving random and directed traffic.
module tb_sd_card_cmd_responder;

  localparam int unsigned NCR = 2;

  logic        ex_clk;
  logic        reset;
  logic        sd_clk;
  logic        cmd_in;
  logic        cmd_out;
  logic        cmd_oe;
  logic        cmd_valid;
  logic [5:0]  cmd_index;
  logic [31:0] cmd_arg;
  logic        cmd_crc_err;
  logic        resp_start;
  logic        resp_skip;
  logic [5:0]  resp_index;
  logic [31:0] resp_arg;
  logic        resp_no_crc;
  logic        resp_done;

  int checks;
  int errors;
  int done_cnt;
  int oe_cycles;
  logic [5:0]  last_idx;
  logic [31:0] last_arg;

  sd_card_cmd_responder #(.NCR(NCR)) dut (
    .ex_clk      (ex_clk),
    .reset       (reset),
    .sd_clk      (sd_clk),
    .cmd_in      (cmd_in),
    .cmd_out     (cmd_out),
    .cmd_oe      (cmd_oe),
    .cmd_valid   (cmd_valid),
    .cmd_index   (cmd_index),
    .cmd_arg     (cmd_arg),
    .cmd_crc_err (cmd_crc_err),
    .resp_start  (resp_start),
    .resp_skip   (resp_skip),
    .resp_index  (resp_index),
    .resp_arg    (resp_arg),
    .resp_no_crc (resp_no_crc),
    .resp_done   (resp_done)
  );

  initial begin
    ex_clk = 1'b0;
    forever #5 ex_clk = ~ex_clk;
  end

  // sd_clk is 8x slower and toggles away from ex_clk edges.
  initial begin
    sd_clk = 1'b0;
    #2;
    forever #40 sd_clk = ~sd_clk;
  end

  always @(negedge ex_clk) begin
    if (resp_done) done_cnt++;
    if (cmd_oe) oe_cycles++;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end

  function automatic logic [6:0] crc7(input logic [39:0] d);
    logic [6:0] c;
    logic fb;
    c = 7'h00;
    for (int i = 39; i >= 0; i--) begin
      fb = d[i] ^ c[6];
      c  = {c[5:0], 1'b0};
      if (fb) c = c ^ 7'h09;
    end
    return c;
  endfunction

  function automatic logic [47:0] mk_cmd(input logic [5:0] idx, input logic [31:0] arg);
    logic [39:0] h;
    h = {2'b01, idx, arg};
    return {h, crc7(h), 1'b1};
  endfunction

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Host sends a frame; returns whether the card should now await a response.
  task automatic cmd_txn(input logic [47:0] f, output bit accepted);
    bit exp_valid;
    bit exp_err;
    for (int i = 47; i >= 0; i--) begin
      @(negedge sd_clk);
      cmd_in = f[i];
    end
    @(posedge sd_clk);
    @(negedge ex_clk);
    cmd_in    = 1'b1;
    exp_valid = f[46] & f[0];
    exp_err   = (f[7:1] != crc7(f[47:8]));
    check_val("cmd_valid", 64'(cmd_valid), 64'(exp_valid));
    if (exp_valid) begin
      check_val("cmd_index", 64'(cmd_index), 64'(f[45:40]));
      check_val("cmd_arg", 64'(cmd_arg), 64'(f[39:8]));
      check_val("cmd_crc_err", 64'(cmd_crc_err), 64'(exp_err));
      last_idx = f[45:40];
      last_arg = f[39:8];
    end else begin
      check_val("index_held", 64'(cmd_index), 64'(last_idx));
      check_val("arg_held", 64'(cmd_arg), 64'(last_arg));
    end
    @(negedge ex_clk);
    check_val("valid_pulse", 64'(cmd_valid), 64'd0);
    accepted = exp_valid & ~exp_err;
  endtask

  task automatic pulse_skip();
    @(negedge ex_clk);
    resp_skip = 1'b1;
    @(negedge ex_clk);
    resp_skip = 1'b0;
  endtask

  // Issue resp_start and check that CMD stays released for n rises.
  task automatic expect_silent(input int n);
    int oe0;
    oe0 = oe_cycles;
    @(negedge ex_clk);
    resp_start = 1'b1;
    resp_index = 6'h2A;
    resp_arg   = 32'h12345678;
    @(negedge ex_clk);
    resp_start = 1'b0;
    for (int i = 0; i < n; i++) @(posedge sd_clk);
    check_val("no_drive", 64'(oe_cycles - oe0), 64'd0);
  endtask

  // Request a response and capture it on sd_clk rises; abort_bits>0 stops early.
  task automatic respond(input logic [5:0] idx, input logic [31:0] arg, input logic nocrc,
                         input int abort_bits);
    logic [39:0] h;
    logic [47:0] exp_f;
    logic [47:0] got;
    int rel;
    int nb;
    int done0;
    h     = {2'b00, idx, arg};
    exp_f = {h, (nocrc ? 7'h7F : crc7(h)), 1'b1};
    got   = '0;
    rel   = 0;
    nb    = 0;
    @(posedge sd_clk);
    @(negedge ex_clk);
    resp_start  = 1'b1;
    resp_index  = idx;
    resp_arg    = arg;
    resp_no_crc = nocrc;
    @(negedge ex_clk);
    resp_start  = 1'b0;
    resp_index  = 6'($urandom);
    resp_arg    = $urandom;
    resp_no_crc = 1'($urandom);
    done0 = done_cnt;
    for (int b = 0; b < 200 && nb < 48; b++) begin
      @(posedge sd_clk);
      if (cmd_oe) begin
        got = {got[46:0], cmd_out};
        nb++;
      end else if (nb == 0) begin
        rel++;
      end else begin
        break;
      end
      if (abort_bits > 0 && nb == abort_bits) break;
    end
    if (abort_bits > 0) begin
      check_val("abort_prefix", 64'(got[27:0]), 64'(exp_f[47:20]));
      return;
    end
    check_val("resp_len", 64'(nb), 64'd48);
    check_val("resp_frame", 64'(got), 64'(exp_f));
    check_val("ncr_gap", 64'(rel), 64'(NCR));
    @(posedge sd_clk);
    check_val("oe_release", 64'(cmd_oe), 64'd0);
    check_val("idle_high", 64'(cmd_out), 64'd1);
    check_val("resp_done", 64'(done_cnt - done0), 64'd1);
  endtask

  initial begin
    bit acc;
    logic [47:0] f;
    int oe0;
    int done0;
    int mode;
    int b;

    checks      = 0;
    errors      = 0;
    done_cnt    = 0;
    oe_cycles   = 0;
    last_idx    = 6'd0;
    last_arg    = 32'd0;
    reset       = 1'b1;
    cmd_in      = 1'b1;
    resp_start  = 1'b0;
    resp_skip   = 1'b0;
    resp_index  = 6'd0;
    resp_arg    = 32'd0;
    resp_no_crc = 1'b0;

    repeat (4) @(negedge ex_clk);
    check_val("rst_cmd_out", 64'(cmd_out), 64'd1);
    check_val("rst_cmd_oe", 64'(cmd_oe), 64'd0);
    check_val("rst_cmd_valid", 64'(cmd_valid), 64'd0);
    check_val("rst_cmd_index", 64'(cmd_index), 64'd0);
    check_val("rst_cmd_arg", 64'(cmd_arg), 64'd0);
    check_val("rst_crc_err", 64'(cmd_crc_err), 64'd0);
    check_val("rst_resp_done", 64'(resp_done), 64'd0);
    reset = 1'b0;
    repeat (4) @(negedge ex_clk);

    // CMD0 then skip: CMD never driven.
    oe0 = oe_cycles;
    cmd_txn(48'h40_0000_0000_95, acc);
    check_val("cmd0_accept", 64'(acc), 64'd1);
    pulse_skip();
    repeat (4) @(posedge sd_clk);
    check_val("cmd0_no_drive", 64'(oe_cycles - oe0), 64'd0);

    // CMD8 with R7-style echo.
    cmd_txn(48'h48_0000_01AA_87, acc);
    check_val("cmd8_accept", 64'(acc), 64'd1);
    respond(6'd8, 32'h0000_01AA, 1'b0, 0);

    // CMD17 with R1.
    cmd_txn(48'h51_0000_0000_55, acc);
    check_val("cmd17_accept", 64'(acc), 64'd1);
    respond(6'd17, 32'h0000_0900, 1'b0, 0);

    // CMD8 with a flipped argument bit: CRC error, response ignored.
    cmd_txn(48'h48_0000_01AA_87 ^ 48'h0000_0001_0000, acc);
    check_val("badcrc_reject", 64'(acc), 64'd0);
    expect_silent(56);

    // ACMD41 with R3 (fixed CRC field).
    cmd_txn(mk_cmd(6'd41, 32'h40FF_8000), acc);
    respond(6'h3F, 32'h80FF_8000, 1'b1, 0);

    // Reset during TX around bit 20, then a clean CMD0.
    cmd_txn(48'h51_0000_0000_55, acc);
    respond(6'd17, 32'h0000_0900, 1'b0, 28);
    @(negedge ex_clk);
    reset = 1'b1;
    @(negedge ex_clk);
    reset = 1'b0;
    check_val("rst_tx_oe", 64'(cmd_oe), 64'd0);
    check_val("rst_tx_out", 64'(cmd_out), 64'd1);
    done0 = done_cnt;
    last_idx = 6'd0;
    last_arg = 32'd0;
    repeat (4) @(posedge sd_clk);
    check_val("rst_tx_no_done", 64'(done_cnt - done0), 64'd0);
    cmd_txn(48'h40_0000_0000_95, acc);
    pulse_skip();

    // Randomised traffic.
    for (int t = 0; t < 24; t++) begin
      mode = int'($urandom_range(0, 4));
      f    = mk_cmd(6'($urandom), $urandom);
      case (mode)
        0: begin
          cmd_txn(f, acc);
          respond(6'($urandom), $urandom, 1'($urandom), 0);
        end
        1: begin
          b = int'($urandom_range(1, 45));
          f[b] = ~f[b];
          cmd_txn(f, acc);
          if (acc) pulse_skip();
          else expect_silent(56);
        end
        2: begin
          if ($urandom_range(0, 1) == 0) f[46] = 1'b0;
          else f[0] = 1'b0;
          cmd_txn(f, acc);
        end
        3: begin
          oe0 = oe_cycles;
          cmd_txn(f, acc);
          pulse_skip();
          repeat (3) @(posedge sd_clk);
          check_val("skip_no_drive", 64'(oe_cycles - oe0), 64'd0);
        end
        default: begin
          cmd_txn(f, acc);
          cmd_txn(mk_cmd(6'($urandom), $urandom), acc);
          respond(6'($urandom), $urandom, 1'($urandom), 0);
        end
      endcase
      if (!acc && mode != 1) repeat (2) @(posedge sd_clk);
    end

    repeat (4) @(negedge ex_clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sd_card_cmd_responder.md
# sd_card_cmd_responder

Card-side model of the SD CMD line: it deserialises 48-bit host commands, checks their CRC7, and serialises 48-bit responses (R1/R3/R6/R7) with a generated CRC7. It runs on `ex_clk` and oversamples `sd_clk`: it samples CMD on `sd_clk` rising edges and drives CMD on falling edges. It is the far end of `sd_send`/`sd_receive` and serves as the bench card model and the core of a future card emulator.

## Interface
- `NCR`, default 2: number of `sd_clk` falling edges with CMD released before the response start bit; legal range 2..64.
- `ex_clk`  in  1  system clock; must be at least 4x `sd_clk`.
- `reset`  in  1  synchronous, active-high; one clock, reset is synchronous and active-high.
- `sd_clk`  in  1  SD clock, sampled as data, never used as a clock.
- `cmd_in`  in  1  CMD pin value.
- `cmd_out`  out  1  CMD drive value; reset 1.
- `cmd_oe`  out  1  CMD output enable; reset 0.
- `cmd_valid`  out  1  one-cycle pulse when a command frame is complete; reset 0.
- `cmd_index`  out  6  command index; held until the next `cmd_valid`; reset 0.
- `cmd_arg`  out  32  command argument; held; reset 0.
- `cmd_crc_err`  out  1  qualified by `cmd_valid`; 1 = CRC7 mismatch; reset 0.
- `resp_start`  in  1  one-cycle request to send a response; honoured only in `RESP_WAIT`.
- `resp_skip`  in  1  no response for this command (e.g. CMD0); honoured only in `RESP_WAIT`.
- `resp_index`  in  6  response bits [45:40]; sampled on `resp_start`.
- `resp_arg`  in  32  response bits [39:8]; sampled on `resp_start`.
- `resp_no_crc`  in  1  sampled on `resp_start`; 1 = send CRC field 7'h7F (R3).
- `resp_done`  out  1  one-cycle pulse after `cmd_oe` falls; reset 0.

## Operation
- Edge detect: `sd_clk_q` is `sd_clk` registered. `rise = sd_clk & ~sd_clk_q`, `fall = ~sd_clk & sd_clk_q`. Reset sets `sd_clk_q` to 0.
- `IDLE`: on `rise` with `cmd_in`=0 (start bit) and `cmd_oe`=0, go to `RX` with bit count 46.
- `RX`: shift `cmd_in` on each `rise`. After 47 further bits the frame is complete. Then:
  - If bit 46 (transmission bit) is 0, or bit 0 (end bit) is 0, discard the frame silently and return to `IDLE`.
  - Otherwise pulse `cmd_valid`, update `cmd_index`/`cmd_arg`, and set `cmd_crc_err` = (received CRC != CRC7 of bits [47:8]).
  - If the CRC is good, go to `RESP_WAIT`. If `cmd_crc_err`=1, go to `IDLE` (a card does not respond to a bad command).
- `RESP_WAIT`:
  - `resp_start` loads the 40-bit header and goes to `NCR_WAIT`.
  - `resp_skip` goes to `IDLE`.
  - `resp_start` and `resp_skip` in the same cycle: `resp_start` wins.
  - A new start bit on `rise` abandons the response and goes to `RX`.
- `NCR_WAIT`: count NCR `fall` events. On the next `fall`, assert `cmd_oe` and drive bit 47 (0), then go to `TX`.
- `TX`: drive the next bit on each `fall`: bit 46 = 0, index, arg, CRC7 (or 7'h7F), end bit 1. CRC7 is computed serially while the header shifts out. On the `fall` after the end bit, drop `cmd_oe`, set `cmd_out` to 1, pulse `resp_done`, and go to `IDLE`.
- CRC7: polynomial x^7+x^3+1, initial value 0, computed MSB first over 40 bits.
- `resp_start`/`resp_skip` in any state other than `RESP_WAIT`: ignored.
- `reset` in any state: all outputs return to their reset values on the next `ex_clk`, CMD is released within one cycle, and the state goes to `IDLE`.

## Timing
- Sampling: a bit is captured the `ex_clk` after `rise` is detected, which is 2 `ex_clk` after `sd_clk` goes high at the input.
- `cmd_valid`: asserted exactly 1 `ex_clk` after the `rise` that sampled the end bit.
- Drive: `cmd_out`/`cmd_oe` change 1 `ex_clk` after `fall`, i.e. 2 `ex_clk` after `sd_clk` goes low.
- Frame lengths: command = 48 rises; response = NCR + 49 falls from `resp_start` acceptance to `cmd_oe` deassertion.
- `resp_done`: asserted 1 `ex_clk` after `cmd_oe` falls.
- No back-pressure: the block never stalls `sd_clk`.

## Structure
- Package `sd_card_pkg` holds:
  - state enum `IDLE`/`RX`/`RESP_WAIT`/`NCR_WAIT`/`TX`;
  - `CRC7_POLY` = 7'h09;
  - `FRAME_BITS` = 48, `HDR_BITS` = 40;
  - `R3_CRC` = 7'h7F.
- One sub-module, `sd_crc7_serial`, provides a 1-bit-per-enable CRC7 with `clear`, `en`, `din`, `crc`. It is instantiated twice: RX check and TX generation.
- Everything else is one FSM, a 48-bit shift register, and a 6-bit bit/NCR counter.

## Test plan
- CMD0 frame 0x40_00000000_95 -> `cmd_valid`, index 0, arg 0, `cmd_crc_err`=0; `resp_skip` -> `IDLE`, CMD never driven.
- CMD8 frame 0x48_000001AA_87 -> index 8, arg 0x1AA, no CRC error. `resp_start` with index 8, arg 0x1AA -> CMD carries 0x08_000001AA_13 after exactly 2 released falls.
- CMD17 frame 0x51_00000000_55. `resp_start` with index 17, arg 0x00000900 -> CMD carries 0x11_00000900_67, then `resp_done`.
- CMD8 frame with one arg bit flipped -> `cmd_valid` with `cmd_crc_err`=1; the block returns to `IDLE` and `resp_start` is ignored.
- ACMD41 response with `resp_no_crc`=1, index 6'h3F, arg 0x80FF8000 -> CMD carries 0x3F_80FF8000_FF.
- `reset` asserted mid-`TX` (bit 20) -> next cycle `cmd_oe`=0, `cmd_out`=1, no `resp_done`. A following CMD0 frame is decoded normally.
